// File: rtl/alarm_tick_scheduler.sv
// Shared-prescaler timebase for the alarm clock: scan/second/fast-advance strobes,
// blink level, and the RUN/PAUSE/SET mode FSM that routes time-advance ticks.
module alarm_tick_scheduler #(
    parameter int BASE_DIV = 100000,
    parameter int SEC_DIV  = 1000,
    parameter int SET_DIV  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_mode,
    input  logic       resync,
    output logic       scan_tick,
    output logic       sec_tick,
    output logic       adv_tick,
    output logic       blink,
    output logic [1:0] state
);

    localparam int BW  = $clog2(BASE_DIV);
    localparam int SW  = $clog2(SEC_DIV);
    localparam int ADW = (SET_DIV > 1) ? $clog2(SET_DIV) : 1;

    localparam logic [BW-1:0]  BASE_MAX = BW'(BASE_DIV - 1);
    localparam logic [SW-1:0]  SEC_MAX  = SW'(SEC_DIV - 1);
    localparam logic [SW-1:0]  SEC_HALF = SW'(SEC_DIV / 2);
    localparam logic [ADW-1:0] ADV_MAX  = ADW'(SET_DIV - 1);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'b00,
        ST_RUN   = 2'b01,
        ST_SET   = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  base_cnt, base_d;
    logic [SW-1:0]  sub_cnt, sub_d;
    logic [ADW-1:0] adv_cnt, adv_d;
    logic           entry_pend, entry_pend_d;
    logic           strobe, set_entry, set_to_run;
    logic           scan_d, sec_d, adv_tick_d, blink_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_PAUSE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = ST_PAUSE;
        if (set_mode)  state_d = ST_SET;
        else if (run)  state_d = ST_RUN;
    end

    assign strobe     = (base_cnt == BASE_MAX);
    assign set_entry  = (state_q != ST_SET) && (state_d == ST_SET);
    assign set_to_run = (state_q == ST_SET) && (state_d == ST_RUN);

    // Later assignments win: mode-transition clears override counting,
    // and resync overrides everything.
    always_comb begin
        base_d = strobe ? '0 : base_cnt + 1'b1;
        sub_d  = sub_cnt;
        adv_d  = adv_cnt;
        if (strobe && state_q != ST_PAUSE)
            sub_d = (sub_cnt == SEC_MAX) ? '0 : sub_cnt + 1'b1;
        if (strobe && state_q == ST_SET)
            adv_d = (adv_cnt == ADV_MAX) ? '0 : adv_cnt + 1'b1;
        if (set_to_run) sub_d = '0;
        if (set_entry)  adv_d = '0;
        if (resync) begin
            base_d = '0;
            sub_d  = '0;
            adv_d  = '0;
        end
    end

    always_comb begin
        scan_d       = strobe && !resync;
        sec_d        = strobe && (sub_cnt == SEC_MAX) && (state_q == ST_RUN) && !resync;
        // The entry pulse lands one cycle after state shows SET.
        adv_tick_d   = (state_q == ST_SET) && !resync &&
                       (entry_pend || (strobe && adv_cnt == ADV_MAX));
        entry_pend_d = set_entry && !resync;
        blink_d      = (state_d == ST_PAUSE) || (sub_d < SEC_HALF);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_cnt   <= '0;
            sub_cnt    <= '0;
            adv_cnt    <= '0;
            entry_pend <= 1'b0;
            scan_tick  <= 1'b0;
            sec_tick   <= 1'b0;
            adv_tick   <= 1'b0;
            blink      <= 1'b1;
        end else begin
            base_cnt   <= base_d;
            sub_cnt    <= sub_d;
            adv_cnt    <= adv_d;
            entry_pend <= entry_pend_d;
            scan_tick  <= scan_d;
            sec_tick   <= sec_d;
            adv_tick   <= adv_tick_d;
            blink      <= blink_d;
        end
    end

    assign state = state_q;

endmodule

// File: doc/alarm_tick_scheduler.md
# alarm_tick_scheduler

Single-clock timebase controller for the alarm clock. It replaces divided-clock outputs with one-cycle enable strobes on `clk`. It schedules, from one shared prescaler, the display scan strobe, the one-second timekeeping tick, the fast-advance tick used while setting time or alarm, and the colon/digit blink level. A small mode FSM arbitrates which consumer receives time-advance ticks: RUN, PAUSE or SET.

## Interface
- `BASE_DIV`, 100000: `clk` cycles per base strobe (1 kHz at 100 MHz); must be ≥2.
- `SEC_DIV`, 1000: base strobes per second; must be even and ≥2.
- `SET_DIV`, 250: base strobes per fast-advance tick (4 Hz); must be ≥1.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; enables timekeeping.
- `set_mode`  in  1  level; user is setting time or alarm; overrides `run`.
- `resync`  in  1  one-cycle pulse; restarts second phase.
- `scan_tick`  out  1  one-cycle strobe per base strobe.
- `sec_tick`  out  1  one-cycle strobe per second, RUN only.
- `adv_tick`  out  1  one-cycle strobe for fast advance, SET only.
- `blink`  out  1  level, 1 Hz, 50% duty.
- `state`  out  2  00 PAUSE, 01 RUN, 10 SET; 11 never driven.

## Operation
- FSM next state, evaluated every cycle: `set_mode`=1 → SET; else `run`=1 → RUN; else PAUSE. Any state may reach any other in one cycle.
- `base_cnt` (width $clog2(BASE_DIV)): free-runs 0..BASE_DIV-1 and wraps in every state. `strobe` = (`base_cnt`==BASE_DIV-1).
- `scan_tick` is registered `strobe`. Scan never stops, including in PAUSE and SET.
- `sub_cnt` (0..SEC_DIV-1):
  - Advances on `strobe` in RUN and SET; holds in PAUSE.
  - Cleared on every transition SET→RUN, so a full second elapses before the first `sec_tick` after setting.
- `sec_tick`: registered (`strobe` & `sub_cnt`==SEC_DIV-1 & state==RUN).
- `adv_cnt` (0..SET_DIV-1):
  - Cleared on entry to SET; advances on `strobe` in SET only.
  - `adv_tick` pulses the cycle after SET is entered, for immediate response to the button.
  - Thereafter `adv_tick` pulses as registered (`strobe` & `adv_cnt`==SET_DIV-1 & state==SET).
- `blink`:
  - PAUSE: forced to 1.
  - RUN and SET: 1 while `sub_cnt` < SEC_DIV/2, else 0.
- `resync`: clears `base_cnt`, `sub_cnt` and `adv_cnt`, and suppresses all ticks that would be generated from that cycle. It takes priority over a coincident `strobe` or mode transition; the FSM still updates.
- `sec_tick` and `adv_tick` are never high in the same cycle.

## Timing
- Reset (`rst`=0), immediate and asynchronous:
  - `state`=00, `scan_tick`=`sec_tick`=`adv_tick`=0, `blink`=1.
  - All counters 0.
- After release, the first active edge evaluates the FSM; counting begins on that edge.
- All outputs are registered, with no combinational path from inputs to outputs.
- `state` reflects inputs one cycle after they are sampled.
- Steady-state periods:
  - `scan_tick`: exactly BASE_DIV cycles.
  - `sec_tick` in RUN: exactly BASE_DIV·SEC_DIV cycles.
  - `adv_tick` in SET: exactly BASE_DIV·SET_DIV cycles after the entry pulse.
- RUN→PAUSE→RUN resumes the second where it left off; there is no phase loss beyond the base-count position.
- Reset mid-operation: all state is discarded, with no partial tick emitted.
- Input `set_mode` held while `run` toggles: remains in SET with no `sec_tick`.

## Test plan
Bench parameters: BASE_DIV=4, SEC_DIV=4, SET_DIV=3.
- Reset release with `run`=1:
  - `state`=01 one cycle later.
  - `scan_tick` every 4 cycles.
  - `sec_tick` every 16 cycles.
  - `blink` alternates 8 cycles high, 8 low.
- RUN, drop `run` mid-second for 20 cycles, then restore:
  - No `sec_tick` during the pause; `blink`=1 throughout.
  - Next `sec_tick` arrives at the remaining portion of the interrupted second.
- Assert `set_mode` during RUN:
  - `adv_tick` one cycle after `state`=10, then every 12 cycles.
  - `sec_tick` stays 0.
  - Release to RUN: first `sec_tick` 16 cycles later (±3 base phase).
- Pulse `resync` on the same cycle `base_cnt`=3 and `sub_cnt`=3:
  - No `scan_tick` or `sec_tick` from that cycle.
  - Next `sec_tick` exactly 16 cycles after `resync`.
- Assert `rst` low mid-second in RUN:
  - All ticks 0, `blink`=1 and `state`=00 before the next edge.
  - After release, behaviour identical to the first scenario.
- Toggle `run` every cycle while `set_mode`=1: `state` stays 10 and `adv_tick` cadence is unaffected.
